// File: rtl/l15_req_arbiter.sv
// Round-robin arbiter for the shared L1.5 request channel. It latches one winner,
// holds it until ack, and tracks per-port in-flight credits by response PID.
module l15_req_arbiter #(
  parameter int NumPorts       = 5,
  parameter int AddrWidth      = 40,
  parameter int MaxOutstanding = 2,
  parameter int PidWidth       = $clog2(NumPorts),
  parameter int CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumPorts-1:0]            req_valid_i,
  output logic [NumPorts-1:0]            req_ready_o,
  input  logic [NumPorts*AddrWidth-1:0]  req_addr_i,
  input  logic [NumPorts*5-1:0]          req_type_i,
  input  logic [NumPorts*3-1:0]          req_size_i,
  output logic                           l15_val_o,
  input  logic                           l15_ack_i,
  output logic [AddrWidth-1:0]           l15_addr_o,
  output logic [4:0]                     l15_type_o,
  output logic [2:0]                     l15_size_o,
  output logic [PidWidth-1:0]            l15_pid_o,
  input  logic                           rtrn_val_i,
  input  logic [PidWidth-1:0]            rtrn_pid_i,
  output logic [NumPorts*CntWidth-1:0]   outstanding_o,
  output logic                           busy_o,
  output logic                           err_o
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [PidWidth:0]   NumPortsExt = (PidWidth + 1)'(NumPorts);
  localparam logic [CntWidth-1:0] CntMax      = CntWidth'(MaxOutstanding);

  state_t                r_state;
  state_t                w_state_next;
  logic [PidWidth-1:0]   r_last_grant;
  logic [AddrWidth-1:0]  r_addr;
  logic [4:0]            r_type;
  logic [2:0]            r_size;
  logic [PidWidth-1:0]   r_pid;
  logic                  r_err;

  logic [NumPorts-1:0]   w_elig;
  logic [NumPorts-1:0]   w_inc;
  logic [NumPorts-1:0]   w_dec_hit;
  logic [NumPorts-1:0]   w_dec_zero;
  logic [NumPorts-1:0]   w_cnt_nz;
  logic                  w_found;
  logic [PidWidth-1:0]   w_winner;
  logic                  w_accept;
  logic                  w_pid_bad;
  logic                  w_err_event;

  // Rotating priority: search starts one past the previous winner.
  always_comb begin
    int w_idx;
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int off = 1; off <= NumPorts; off++) begin
      w_idx = (int'(r_last_grant) + off) % NumPorts;
      if (!w_found && w_elig[w_idx]) begin
        w_found  = 1'b1;
        w_winner = PidWidth'(w_idx);
      end
    end
  end

  assign w_accept = (r_state == IDLE) && w_found;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = SEND;
      SEND:    if (l15_ack_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_last_grant <= PidWidth'(NumPorts - 1);
      r_addr       <= '0;
      r_type       <= '0;
      r_size       <= '0;
      r_pid        <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_last_grant <= w_winner;
        r_pid        <= w_winner;
        r_addr       <= req_addr_i[w_winner*AddrWidth +: AddrWidth];
        r_type       <= req_type_i[w_winner*5 +: 5];
        r_size       <= req_size_i[w_winner*3 +: 3];
      end
    end
  end

  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
    logic [CntWidth-1:0] r_cnt;
    logic                w_dec;

    assign w_elig[gi]      = req_valid_i[gi] && (r_cnt < CntMax);
    assign req_ready_o[gi] = w_accept && (w_winner == PidWidth'(gi));
    assign w_inc[gi]       = req_ready_o[gi];
    assign w_dec_hit[gi]   = rtrn_val_i && (rtrn_pid_i == PidWidth'(gi));
    assign w_dec_zero[gi]  = w_dec_hit[gi] && (r_cnt == '0);
    assign w_dec           = w_dec_hit[gi] && (r_cnt != '0);
    assign w_cnt_nz[gi]    = (r_cnt != '0);
    assign outstanding_o[gi*CntWidth +: CntWidth] = r_cnt;

    // A simultaneous reserve and release cancel out.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_cnt <= '0;
      end else if (w_inc[gi] && !w_dec) begin
        r_cnt <= r_cnt + CntWidth'(1);
      end else if (!w_inc[gi] && w_dec) begin
        r_cnt <= r_cnt - CntWidth'(1);
      end
    end
  end

  assign w_pid_bad   = {1'b0, rtrn_pid_i} >= NumPortsExt;
  assign w_err_event = (|w_dec_zero) || (rtrn_val_i && w_pid_bad) ||
                       (l15_ack_i && (r_state == IDLE));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_err_event) begin
      r_err <= 1'b1;
    end
  end

  assign l15_val_o  = (r_state == SEND);
  assign l15_addr_o = r_addr;
  assign l15_type_o = r_type;
  assign l15_size_o = r_size;
  assign l15_pid_o  = r_pid;
  assign busy_o     = (r_state == SEND) || (|w_cnt_nz);
  assign err_o      = r_err;

endmodule
